// File: rtl/noc_traffic_gen.sv
// rtl/noc_traffic_gen.sv - programmable packet injector for one router-to-router link.
// Emits bursts of deterministic-payload packets under per-VC on/off and allocatability flow control.
package noc_params;
  localparam int DEST_ADDR_SIZE_X  = 2;
  localparam int DEST_ADDR_SIZE_Y  = 2;
  localparam int VC_SIZE           = 1;
  localparam int HEAD_PAYLOAD_SIZE = 16;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [FLIT_DATA_SIZE-1:0]   data;
  } flit_t;
endpackage

module noc_traffic_gen #(
  parameter int VC_NUM    = 2,
  parameter int VC_SIZE   = $clog2(VC_NUM),
  parameter int PKT_LEN_W = 4,
  parameter int GAP_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  logic [VC_SIZE-1:0]                    vc_i,
  input  logic [PKT_LEN_W-1:0]                  pkt_len_i,
  input  logic [GAP_W-1:0]                      gap_i,
  input  logic [CNT_W-1:0]                      num_pkts_i,
  output noc_params::flit_t                     data_o,
  output logic                                  is_valid_o,
  input  logic [VC_NUM-1:0]                     is_on_off_i,
  input  logic [VC_NUM-1:0]                     is_allocatable_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [CNT_W-1:0]                      flits_sent_o
);
  localparam int FVC = noc_params::VC_SIZE;
  localparam int HP  = noc_params::HEAD_PAYLOAD_SIZE;
  localparam int FD  = noc_params::FLIT_DATA_SIZE;

  typedef enum logic [2:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_GAP, ST_FINISH} state_t;

  state_t                                state, state_n;
  logic [noc_params::DEST_ADDR_SIZE_X-1:0] cfg_x, cfg_x_n;
  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] cfg_y, cfg_y_n;
  logic [VC_SIZE-1:0]                    cfg_vc, cfg_vc_n;
  logic [PKT_LEN_W-1:0]                  cfg_len, cfg_len_n;
  logic [GAP_W-1:0]                      cfg_gap, cfg_gap_n;
  logic [CNT_W-1:0]                      cfg_num, cfg_num_n;
  logic [CNT_W-1:0]                      pkt_idx, pkt_idx_n;
  logic [PKT_LEN_W-1:0]                  flit_idx, flit_idx_n;
  logic [GAP_W-1:0]                      gap_cnt, gap_cnt_n;
  noc_params::flit_t                     data_n;
  logic                                  valid_n, busy_n, done_n;
  logic [CNT_W-1:0]                      flits_n;

  logic [CNT_W-1:0] pkt_inc;
  logic             last_pkt;
  state_t           after_tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cfg_x        <= '0;
      cfg_y        <= '0;
      cfg_vc       <= '0;
      cfg_len      <= '0;
      cfg_gap      <= '0;
      cfg_num      <= '0;
      pkt_idx      <= '0;
      flit_idx     <= '0;
      gap_cnt      <= '0;
      data_o       <= '0;
      is_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      flits_sent_o <= '0;
    end else begin
      state        <= state_n;
      cfg_x        <= cfg_x_n;
      cfg_y        <= cfg_y_n;
      cfg_vc       <= cfg_vc_n;
      cfg_len      <= cfg_len_n;
      cfg_gap      <= cfg_gap_n;
      cfg_num      <= cfg_num_n;
      pkt_idx      <= pkt_idx_n;
      flit_idx     <= flit_idx_n;
      gap_cnt      <= gap_cnt_n;
      data_o       <= data_n;
      is_valid_o   <= valid_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      flits_sent_o <= flits_n;
    end
  end

  // Where a packet goes once its last flit is out; the trailing gap also follows the final packet.
  assign pkt_inc    = pkt_idx + 1'b1;
  assign last_pkt   = (pkt_inc == cfg_num);
  assign after_tail = (cfg_gap != '0) ? ST_GAP : (last_pkt ? ST_FINISH : ST_HEAD);

  always_comb begin
    state_n    = state;
    cfg_x_n    = cfg_x;
    cfg_y_n    = cfg_y;
    cfg_vc_n   = cfg_vc;
    cfg_len_n  = cfg_len;
    cfg_gap_n  = cfg_gap;
    cfg_num_n  = cfg_num;
    pkt_idx_n  = pkt_idx;
    flit_idx_n = flit_idx;
    gap_cnt_n  = gap_cnt;
    data_n     = data_o;
    valid_n    = 1'b0;
    busy_n     = busy_o;
    done_n     = 1'b0;
    flits_n    = flits_sent_o;

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          cfg_x_n    = x_dest_i;
          cfg_y_n    = y_dest_i;
          cfg_vc_n   = vc_i;
          cfg_len_n  = (pkt_len_i == '0) ? PKT_LEN_W'(1) : pkt_len_i;
          cfg_gap_n  = gap_i;
          cfg_num_n  = num_pkts_i;
          pkt_idx_n  = '0;
          flit_idx_n = '0;
          flits_n    = '0;
          busy_n     = 1'b1;
          state_n    = (num_pkts_i == '0) ? ST_FINISH : ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (is_on_off_i[cfg_vc] && is_allocatable_i[cfg_vc]) begin
          valid_n           = 1'b1;
          data_n.flit_label = (cfg_len == PKT_LEN_W'(1)) ? noc_params::HEADTAIL : noc_params::HEAD;
          data_n.vc_id      = FVC'(cfg_vc);
          data_n.data       = {cfg_x, cfg_y, HP'(pkt_idx)};
          if (cfg_len != PKT_LEN_W'(1)) begin
            flit_idx_n = PKT_LEN_W'(1);
            state_n    = ST_BODY;
          end else begin
            pkt_idx_n = pkt_inc;
            gap_cnt_n = cfg_gap;
            state_n   = after_tail;
          end
        end
      end
      ST_BODY: begin
        if (is_on_off_i[cfg_vc]) begin
          valid_n           = 1'b1;
          data_n.vc_id      = FVC'(cfg_vc);
          data_n.data       = FD'({pkt_idx, flit_idx});
          if (flit_idx == cfg_len - 1'b1) begin
            data_n.flit_label = noc_params::TAIL;
            pkt_idx_n         = pkt_inc;
            gap_cnt_n         = cfg_gap;
            state_n           = after_tail;
          end else begin
            data_n.flit_label = noc_params::BODY;
            flit_idx_n        = flit_idx + 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_n = gap_cnt - 1'b1;
        if (gap_cnt <= GAP_W'(1)) begin
          state_n = (pkt_idx == cfg_num) ? ST_FINISH : ST_HEAD;
        end
      end
      ST_FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (valid_n) begin
      flits_n = flits_n + 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb/tb_noc_traffic_gen.sv - self-checking bench for noc_traffic_gen.
// Directed scenarios plus randomized bursts checked against a packet-list reference model.
module tb_noc_traffic_gen;
  import noc_params::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  x_dest_i = '0;
  logic [1:0]  y_dest_i = '0;
  logic [0:0]  vc_i = '0;
  logic [3:0]  pkt_len_i = '0;
  logic [3:0]  gap_i = '0;
  logic [15:0] num_pkts_i = '0;
  flit_t       data_o;
  logic        is_valid_o;
  logic [1:0]  is_on_off_i = '1;
  logic [1:0]  is_allocatable_i = '1;
  logic        busy_o;
  logic        done_o;
  logic [15:0] flits_sent_o;

  noc_traffic_gen dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .x_dest_i(x_dest_i), .y_dest_i(y_dest_i), .vc_i(vc_i),
    .pkt_len_i(pkt_len_i), .gap_i(gap_i), .num_pkts_i(num_pkts_i),
    .data_o(data_o), .is_valid_o(is_valid_o),
    .is_on_off_i(is_on_off_i), .is_allocatable_i(is_allocatable_i),
    .busy_o(busy_o), .done_o(done_o), .flits_sent_o(flits_sent_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  flit_t    cap_flit[$];
  int       cap_cyc[$];
  int       done_q[$];
  flit_t    exp_q[$];
  bit [1:0] hist_on[int];
  bit [1:0] hist_al[int];
  int       n_tests = 0;
  int       n_fail = 0;
  int       s;

  always @(negedge clk) begin
    if (is_valid_o) begin
      cap_flit.push_back(data_o);
      cap_cyc.push_back(cyc);
    end
    if (done_o) done_q.push_back(cyc);
  end

  // Reference: the whole burst as an ordered flit list, straight from the packet format rules.
  task automatic build_expected(input int x, input int y, input int vc, input int len, input int num);
    int    eff;
    flit_t f;
    exp_q.delete();
    eff = (len == 0) ? 1 : len;
    for (int p = 0; p < num; p++) begin
      f.vc_id      = 1'(vc);
      f.flit_label = (eff == 1) ? HEADTAIL : HEAD;
      f.data       = 20'((x << (DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE)) + (y << HEAD_PAYLOAD_SIZE) + (p % 65536));
      exp_q.push_back(f);
      for (int fi = 1; fi < eff; fi++) begin
        f.flit_label = (fi == eff - 1) ? TAIL : BODY;
        f.data       = 20'((p % 65536) * 16 + fi);
        exp_q.push_back(f);
      end
    end
  endtask

  task automatic clear_capture();
    cap_flit.delete();
    cap_cyc.delete();
    done_q.delete();
  endtask

  task automatic pulse_start(input int x, input int y, input int vc, input int len, input int gap, input int num);
    @(negedge clk);
    x_dest_i = 2'(x); y_dest_i = 2'(y); vc_i = 1'(vc);
    pkt_len_i = 4'(len); gap_i = 4'(gap); num_pkts_i = 16'(num);
    is_on_off_i = '1; is_allocatable_i = '1;
    start_i = 1'b1;
    s = cyc + 1;
    hist_on[s] = '1; hist_al[s] = '1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_fc,
                           input bit [1:0] on_mask, input int on_lo, input int on_hi,
                           input bit [1:0] al_mask, input int al_lo, input int al_hi, input int al2_lo,
                           output bit ok);
    int       e;
    bit [1:0] on, al;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      e = cyc + 1;
      if (rand_fc) begin
        for (int b = 0; b < 2; b++) begin
          on[b] = ($urandom_range(0, 3) != 0);
          al[b] = ($urandom_range(0, 3) != 0);
        end
        x_dest_i = 2'($urandom); y_dest_i = 2'($urandom); vc_i = 1'($urandom);
        pkt_len_i = 4'($urandom); gap_i = 4'($urandom); num_pkts_i = 16'($urandom);
        start_i = ($urandom_range(0, 7) == 0);
      end else begin
        on = (e >= on_lo && e <= on_hi) ? ~on_mask : 2'b11;
        al = ((e >= al_lo && e <= al_hi) || e >= al2_lo) ? ~al_mask : 2'b11;
      end
      is_on_off_i = on; is_allocatable_i = al;
      hist_on[e] = on; hist_al[e] = al;
      @(negedge clk);
      if (done_o) ok = 1'b1;
    end
    start_i = 1'b0; is_on_off_i = '1; is_allocatable_i = '1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (is_valid_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || flits_sent_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b done=%b sent=%0d, required all zero",
               is_valid_o, data_o, busy_o, done_o, flits_sent_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    bit ok;
    clear_capture();
    build_expected(2, 2, 0, 4, 1);
    pulse_start(2, 2, 0, 4, 0, 1);
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy_o); end
    wait_done(50, 0, 2'b00, 0, -1, 2'b00, 0, -1, 1 << 30, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got no done required done"); end
    n_tests++;
    if (cap_flit.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d required 4", cap_flit.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i] || cap_cyc[i] != s + 1 + i) begin
        n_fail++;
        $display("FAIL single_flit%0d: got %h@%0d required %h@%0d", i, cap_flit[i], cap_cyc[i], exp_q[i], s + 1 + i);
      end
    end
    n_tests++;
    if (done_q.size() != 1 || done_q[0] != s + 5) begin
      n_fail++; $display("FAIL single_done: got %0d pulses first@%0d required 1@%0d", done_q.size(), done_q.size() ? done_q[0] : -1, s + 5);
    end
    n_tests++;
    if (flits_sent_o !== 16'd4 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_sent: got %0d busy=%b required 4 busy=0", flits_sent_o, busy_o);
    end
  endtask

  task automatic test_gap_headtail();
    bit ok;
    clear_capture();
    build_expected(1, 3, 0, 1, 3);
    pulse_start(1, 3, 0, 1, 2, 3);
    wait_done(80, 0, 2'b00, 0, -1, 2'b00, 0, -1, 1 << 30, ok);
    n_tests++;
    if (!ok || cap_flit.size() != 3) begin
      n_fail++; $display("FAIL gap_count: got %0d flits done=%b required 3 done=1", cap_flit.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i] || cap_cyc[i] != s + 1 + 3 * i) begin
        n_fail++;
        $display("FAIL gap_flit%0d: got %h@%0d required %h@%0d", i, cap_flit[i], cap_cyc[i], exp_q[i], s + 1 + 3 * i);
      end
    end
    n_tests++;
    if (flits_sent_o !== 16'd3 || done_q.size() != 1 || done_q[0] != s + 10) begin
      n_fail++; $display("FAIL gap_done: got sent=%0d done@%0d required 3 done@%0d",
                         flits_sent_o, done_q.size() ? done_q[0] : -1, s + 10);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_capture();
    build_expected(3, 0, 0, 2, 3);
    pulse_start(3, 0, 0, 2, 0, 3);
    wait_done(80, 0, 2'b10, 0, 1 << 30, 2'b10, 0, -1, 0, ok);
    n_tests++;
    if (!ok || cap_flit.size() != 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d flits done=%b required 6 done=1", cap_flit.size(), ok);
    end
    for (int i = 0; i < exp_q.size() && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i] || cap_cyc[i] != s + 1 + i) begin
        n_fail++;
        $display("FAIL b2b_flit%0d: got %h@%0d required %h@%0d", i, cap_flit[i], cap_cyc[i], exp_q[i], s + 1 + i);
      end
    end
  endtask

  task automatic test_on_off_stall();
    bit ok;
    int ec[4];
    clear_capture();
    build_expected(0, 1, 1, 4, 1);
    pulse_start(0, 1, 1, 4, 0, 1);
    ec[0] = s + 1; ec[1] = s + 5; ec[2] = s + 6; ec[3] = s + 7;
    wait_done(80, 0, 2'b10, s + 2, s + 4, 2'b00, 0, -1, 1 << 30, ok);
    n_tests++;
    if (!ok || cap_flit.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d flits done=%b required 4 done=1", cap_flit.size(), ok);
    end
    for (int i = 0; i < 4 && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i] || cap_cyc[i] != ec[i]) begin
        n_fail++;
        $display("FAIL stall_flit%0d: got %h@%0d required %h@%0d", i, cap_flit[i], cap_cyc[i], exp_q[i], ec[i]);
      end
    end
  endtask

  task automatic test_allocatable();
    bit ok;
    clear_capture();
    build_expected(2, 1, 0, 4, 1);
    pulse_start(2, 1, 0, 4, 0, 1);
    wait_done(80, 0, 2'b00, 0, -1, 2'b01, s + 1, s + 5, s + 7, ok);
    n_tests++;
    if (!ok || cap_flit.size() != 4) begin
      n_fail++; $display("FAIL alloc_count: got %0d flits done=%b required 4 done=1", cap_flit.size(), ok);
    end
    for (int i = 0; i < 4 && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i] || cap_cyc[i] != s + 6 + i) begin
        n_fail++;
        $display("FAIL alloc_flit%0d: got %h@%0d required %h@%0d", i, cap_flit[i], cap_cyc[i], exp_q[i], s + 6 + i);
      end
    end
  endtask

  task automatic test_zero_packets();
    bit ok;
    clear_capture();
    pulse_start(1, 1, 1, 5, 3, 0);
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL zero_busy_hi: got %b required 1", busy_o); end
    wait_done(20, 0, 2'b00, 0, -1, 2'b00, 0, -1, 1 << 30, ok);
    n_tests++;
    if (!ok || done_q.size() != 1 || done_q[0] != s + 1 || cap_flit.size() != 0 || busy_o !== 1'b0 || flits_sent_o !== '0) begin
      n_fail++;
      $display("FAIL zero_pkts: got done@%0d flits=%0d busy=%b sent=%0d required done@%0d flits=0 busy=0 sent=0",
               done_q.size() ? done_q[0] : -1, cap_flit.size(), busy_o, flits_sent_o, s + 1);
    end
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    pulse_start(1, 2, 0, 4, 0, 1);
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (is_valid_o !== 1'b1 || data_o.flit_label !== BODY) begin
      n_fail++; $display("FAIL rstmid_pre: got valid=%b label=%0d required valid=1 BODY", is_valid_o, data_o.flit_label);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (is_valid_o !== 1'b0 || busy_o !== 1'b0 || flits_sent_o !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b busy=%b sent=%0d required 0 0 0", is_valid_o, busy_o, flits_sent_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_capture();
    build_expected(3, 1, 1, 2, 2);
    pulse_start(3, 1, 1, 2, 1, 2);
    wait_done(80, 0, 2'b00, 0, -1, 2'b00, 0, -1, 1 << 30, ok);
    n_tests++;
    if (!ok || cap_flit.size() != 4 || flits_sent_o !== 16'd4) begin
      n_fail++; $display("FAIL rstmid_restart: got %0d flits sent=%0d done=%b required 4 4 1", cap_flit.size(), flits_sent_o, ok);
    end
    for (int i = 0; i < exp_q.size() && i < cap_flit.size(); i++) begin
      n_tests++;
      if (cap_flit[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_flit%0d: got %h required %h", i, cap_flit[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int x, y, vc, len, gap, num, c;
    for (int r = 0; r < 10; r++) begin
      x = $urandom_range(0, 3); y = $urandom_range(0, 3); vc = $urandom_range(0, 1);
      len = $urandom_range(0, 15); gap = $urandom_range(0, 3); num = $urandom_range(0, 4);
      clear_capture();
      build_expected(x, y, vc, len, num);
      pulse_start(x, y, vc, len, gap, num);
      wait_done(3000, 1, 2'b00, 0, -1, 2'b00, 0, -1, 1 << 30, ok);
      n_tests++;
      if (!ok || done_q.size() != 1) begin
        n_fail++; $display("FAIL rand%0d_done: got done=%b pulses=%0d required 1", r, ok, done_q.size());
      end
      n_tests++;
      if (cap_flit.size() != exp_q.size() || flits_sent_o !== 16'(exp_q.size())) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d sent=%0d required %0d", r, cap_flit.size(), flits_sent_o, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_flit.size(); i++) begin
        c = cap_cyc[i];
        n_tests++;
        if (cap_flit[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_flit%0d: got %h required %h", r, i, cap_flit[i], exp_q[i]);
        end
        n_tests++;
        if (!hist_on[c][vc] || ((exp_q[i].flit_label == HEAD || exp_q[i].flit_label == HEADTAIL) && !hist_al[c][vc])) begin
          n_fail++; $display("FAIL rand%0d_fc%0d: got flit@%0d with on=%b al=%b required credit", r, i, c, hist_on[c], hist_al[c]);
        end
        if (i > 0 && (exp_q[i - 1].flit_label == TAIL || exp_q[i - 1].flit_label == HEADTAIL)) begin
          n_tests++;
          if (c - cap_cyc[i - 1] < gap + 1) begin
            n_fail++; $display("FAIL rand%0d_gap%0d: got spacing %0d required >= %0d", r, i, c - cap_cyc[i - 1], gap + 1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_gap_headtail();
    test_back_to_back();
    test_on_off_stall();
    test_allocatable();
    test_zero_packets();
    test_reset_midpacket();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_traffic_gen.md
Name: noc_traffic_gen

Overview:
- Synthesizable, parametrised packet injector for one router2router upstream link; the successor to the behavioural flit driver used around the router.
- Generates a programmed burst of packets: configurable destination, VC, packet length, inter-packet gap and packet count.
- Honours per-VC on/off flow control and VC allocatability.
- Emits deterministic payloads so that a downstream checker can predict every flit.

Parameters:
- VC_NUM, 2, virtual channels on the link.
- VC_SIZE, $clog2(VC_NUM), VC index width.
- PKT_LEN_W, 4, width of the packet-length field; max length 2^PKT_LEN_W-1 flits.
- GAP_W, 4, width of the inter-packet idle-cycle field.
- CNT_W, 16, width of the packet-count and flit-counter fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; latches config and begins a burst when idle
- x_dest_i  in  DEST_ADDR_SIZE_X  destination X (noc_params)
- y_dest_i  in  DEST_ADDR_SIZE_Y  destination Y
- vc_i  in  VC_SIZE  VC used for the whole burst
- pkt_len_i  in  PKT_LEN_W  flits per packet; 0 is treated as 1
- gap_i  in  GAP_W  idle cycles inserted after each tail
- num_pkts_i  in  CNT_W  packets in burst; 0 means no packets
- data_o  out  flit_t  flit to downstream
- is_valid_o  out  1  data_o valid this cycle
- is_on_off_i  in  VC_NUM  per-VC credit-on; 1 = downstream may accept
- is_allocatable_i  in  VC_NUM  per-VC free for a new head
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse after the final flit of the burst
- flits_sent_o  out  CNT_W  flits emitted since the last start_i, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; is_valid_o=0, data_o='0, busy_o=0, done_o=0, flits_sent_o=0. Reset asserted mid-packet abandons the packet immediately, with no tail emitted.
- All outputs are registered. A flit is "sent" in any cycle where is_valid_o=1. There is no ready signal; the block only asserts valid when flow control permits.

FSM:
- IDLE:
  - start_i=1 latches all config, clears flits_sent_o, clears pkt_idx and flit_idx, asserts busy_o.
  - If num_pkts_i=0: go to FINISH. Otherwise go to HEAD.
  - start_i is ignored outside IDLE.
- HEAD:
  - Emit the head on the next edge only if is_on_off_i[vc] && is_allocatable_i[vc]; otherwise hold with is_valid_o=0.
  - Label is HEADTAIL if effective length = 1, else HEAD.
  - Head fields: vc_id=vc, x_dest, y_dest; head_pl = pkt_idx zero-extended/truncated to HEAD_PAYLOAD_SIZE.
  - Next state: BODY if length > 1; else GAP if gap > 0; else HEAD or FINISH.
- BODY:
  - Emit one flit per cycle while is_on_off_i[vc]=1; stall (is_valid_o=0) while it is 0. is_allocatable_i is ignored here.
  - flit_idx counts 1..len-1. Flit len-1 carries label TAIL, all others BODY.
  - bt_pl = {pkt_idx, flit_idx} packed LSB-aligned into FLIT_DATA_SIZE; upper bits zero, excess bits truncated.
  - After the tail: pkt_idx++ and go to GAP if gap > 0, else HEAD; if this was the last packet, go to FINISH.
- GAP:
  - Counter loads gap_i on entry and idles exactly gap cycles with is_valid_o=0.
  - Then go to HEAD, or FINISH if this was the last packet.
- FINISH:
  - done_o=1 for one cycle, busy_o=0, then IDLE.

Timing and boundary rules:
- Latency: start_i sampled at edge N; the earliest head has is_valid_o=1 after edge N+1.
- Back-to-back: with gap=0 and credits held on, the next head immediately follows the tail (no bubble), provided allocatable=1.
- Flow control is evaluated on the input values at the same edge that registers the flit. A deasserting on_off therefore blocks the flit in that same cycle.
- flits_sent_o increments by exactly 1 per valid flit. It saturates never; it wraps.
- vc_id equals the latched vc on every flit. Config inputs changed mid-burst have no effect.
- A new start_i in the FINISH cycle is ignored.

Test Plan:
- Reset, then start with dest(2,2), vc=0, len=4, gap=0, num=1, all credits on -> HEAD, BODY, BODY, TAIL on 4 consecutive cycles starting at N+1; bt_pl=1,2,3; done_o pulses the following cycle; flits_sent_o=4.
- len=1, num=3, gap=2 -> HEADTAIL flits with head_pl 0,1,2, separated by exactly 2 invalid cycles; flits_sent_o=3.
- len=4, vc=1, drop is_on_off_i[1] for 3 cycles after the head -> valid gap of exactly 3 cycles; no flit lost or duplicated; order is BODY1, BODY2, TAIL.
- is_allocatable_i[vc]=0 for 5 cycles after start -> no head is emitted until it rises; body flits are unaffected by later allocatable toggles.
- num=0 -> busy_o stays high 1 cycle, done_o pulses, no valid flits.
- rst pulled low after the second flit of a 4-flit packet -> is_valid_o=0 asynchronously, state IDLE, flits_sent_o=0; a new start restarts cleanly with head_pl=0.
